// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence detectors:
// FSM state encoding and the default power-up pattern.
package seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    GAP  = ST_GAP,
    DONE = ST_DONE
  } seq_state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register. Load has priority over shift;
// zeros are shifted in at the LSB end.
module seq_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr_reg;
  logic [W-1:0] sr_next;
  logic [W-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shifted[gi] = 1'b0;
      end else begin : g_upper
        assign shifted[gi] = sr_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    sr_next = sr_reg;
    if (load) begin
      sr_next = din;
    end else if (shift) begin
      sr_next = shifted;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_reg <= '0;
    end else begin
      sr_reg <= sr_next;
    end
  end

  assign msb = sr_reg[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first, repeats it
// rep times with optional zero-bit gaps between repetitions. All outputs registered.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_pat,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             x_out,
  output logic             valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int               BC_W     = $clog2(PAT_W);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(PAT_W - 1);

  seq_state_t       state_reg, state_next;
  logic [PAT_W-1:0] pattern_reg, pattern_next;
  logic [PAT_W-1:0] snap_reg, snap_next;
  logic [CNT_W-1:0] rep_reg, rep_next;
  logic [GAP_W-1:0] gap_ld_reg, gap_ld_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [BC_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic             x_out_reg, x_out_next;
  logic             valid_reg, valid_next;
  logic             frame_start_reg, frame_start_next;
  logic             done_reg, done_next;

  logic             reload;
  logic [PAT_W-1:0] reload_src;
  logic [CNT_W-1:0] rep_dec;
  logic             piso_load;
  logic             piso_shift;
  logic [PAT_W-1:0] piso_din;
  logic             piso_msb;

  // The shifter holds the bits that follow the one currently on x_out, so a
  // reload presents the MSB directly and parks the remaining bits in the shifter.
  seq_piso #(
    .W(PAT_W)
  ) u_piso (
    .clk  (clk),
    .reset(reset),
    .load (piso_load),
    .shift(piso_shift),
    .din  (piso_din),
    .msb  (piso_msb)
  );

  always_comb begin
    state_next       = state_reg;
    pattern_next     = pattern_reg;
    snap_next        = snap_reg;
    rep_next         = rep_reg;
    gap_ld_next      = gap_ld_reg;
    gap_cnt_next     = gap_cnt_reg;
    bit_cnt_next     = bit_cnt_reg;
    x_out_next       = 1'b0;
    valid_next       = 1'b0;
    frame_start_next = 1'b0;
    done_next        = 1'b0;
    piso_load        = 1'b0;
    piso_shift       = 1'b0;
    reload           = 1'b0;
    reload_src       = snap_reg;
    rep_dec          = '0;

    case (state_reg)
      IDLE: begin
        if (load_pat) begin
          pattern_next = pattern_in;
        end
        if (start) begin
          // A simultaneous load makes the new pattern the one transmitted.
          reload_src  = load_pat ? pattern_in : pattern_reg;
          snap_next   = reload_src;
          rep_next    = repeat_cnt;
          gap_ld_next = gap;
          if (repeat_cnt != '0) begin
            reload = 1'b1;
          end else begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
      end

      SEND: begin
        if (bit_cnt_reg != LAST_BIT) begin
          bit_cnt_next = bit_cnt_reg + BC_W'(1);
          x_out_next   = piso_msb;
          valid_next   = 1'b1;
          piso_shift   = 1'b1;
        end else begin
          rep_dec  = (rep_reg != '0) ? rep_reg - CNT_W'(1) : '0;
          rep_next = rep_dec;
          if (rep_dec == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else if (gap_ld_reg != '0) begin
            state_next   = GAP;
            gap_cnt_next = gap_ld_reg - GAP_W'(1);
            valid_next   = 1'b1;
          end else begin
            reload = 1'b1;
          end
        end
      end

      GAP: begin
        if (gap_cnt_reg != '0) begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
          valid_next   = 1'b1;
        end else begin
          reload = 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (reload) begin
      state_next       = SEND;
      bit_cnt_next     = '0;
      x_out_next       = reload_src[PAT_W-1];
      valid_next       = 1'b1;
      frame_start_next = 1'b1;
      piso_load        = 1'b1;
    end
    piso_din = {reload_src[PAT_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      pattern_reg     <= PATTERN;
      snap_reg        <= '0;
      rep_reg         <= '0;
      gap_ld_reg      <= '0;
      gap_cnt_reg     <= '0;
      bit_cnt_reg     <= '0;
      x_out_reg       <= 1'b0;
      valid_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pattern_reg     <= pattern_next;
      snap_reg        <= snap_next;
      rep_reg         <= rep_next;
      gap_ld_reg      <= gap_ld_next;
      gap_cnt_reg     <= gap_cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      x_out_reg       <= x_out_next;
      valid_reg       <= valid_next;
      frame_start_reg <= frame_start_next;
      done_reg        <= done_next;
    end
  end

  assign x_out       = x_out_reg;
  assign valid       = valid_reg;
  assign frame_start = frame_start_reg;
  assign done        = done_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: each run's per-cycle output stream is
// predicted from the pattern/repeat/gap rules and compared cycle by cycle.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_pat;
  logic [PAT_W-1:0] pattern_in;
  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             x_out;
  logic             valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_mis = 0;

  logic [PAT_W-1:0] pat_model;

  typedef struct packed {
    logic v;
    logic x;
    logic fs;
    logic d;
    logic b;
  } exp_t;

  exp_t exp_q[$];

  seq_pattern_gen #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .GAP_W(GAP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_pat   (load_pat),
    .pattern_in (pattern_in),
    .start      (start),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .x_out      (x_out),
    .valid      (valid),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(logic v, logic x, logic fs, logic d, logic b);
    exp_t e;
    e.v = v; e.x = x; e.fs = fs; e.d = d; e.b = b;
    return e;
  endfunction

  // Expected stream: rep copies of the pattern MSB-first, gap zeros between
  // copies, then one done cycle, then one idle cycle.
  task automatic build_expected(input int rep, input int gp, input logic [PAT_W-1:0] pat);
    exp_q.delete();
    for (int r = 0; r < rep; r++) begin
      for (int b = 0; b < PAT_W; b++) exp_q.push_back(mk(1'b1, pat[PAT_W-1-b], b == 0, 1'b0, 1'b1));
      if (r < rep - 1)
        for (int g = 0; g < gp; g++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic run(input string tag, input int rep, input int gp,
                     input logic do_load, input logic [PAT_W-1:0] new_pat, input logic noise);
    string bits;
    int    n_valid;
    bits    = "";
    n_valid = 0;
    @(negedge clk);
    load_pat   = do_load;
    pattern_in = new_pat;
    start      = 1'b1;
    repeat_cnt = CNT_W'(rep);
    gap        = GAP_W'(gp);
    if (do_load) pat_model = new_pat;
    build_expected(rep, gp, pat_model);
    @(posedge clk);
    #1;
    start      = 1'b0;
    load_pat   = 1'b0;
    repeat_cnt = CNT_W'($urandom);
    gap        = GAP_W'($urandom);
    pattern_in = PAT_W'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s.valid[%0d]", tag, i), 32'(valid), 32'(exp_q[i].v));
      chk($sformatf("%s.x_out[%0d]", tag, i), 32'(x_out), 32'(exp_q[i].x));
      chk($sformatf("%s.frame_start[%0d]", tag, i), 32'(frame_start), 32'(exp_q[i].fs));
      chk($sformatf("%s.done[%0d]", tag, i), 32'(done), 32'(exp_q[i].d));
      chk($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'(exp_q[i].b));
      if (valid === 1'b1) begin
        n_valid++;
        if (bits.len() < 64) bits = {bits, (x_out === 1'b1) ? "1" : "0"};
      end
      if (noise && i < exp_q.size() - 1) begin
        start      = 1'($urandom_range(0, 1));
        load_pat   = 1'($urandom_range(0, 1));
        pattern_in = PAT_W'($urandom);
      end else begin
        start    = 1'b0;
        load_pat = 1'b0;
      end
    end
    $display("run %s: rep=%0d gap=%0d pat=%b valid_cycles=%0d stream=%s",
             tag, rep, gp, pat_model, n_valid, bits);
  endtask

  initial begin
    reset      = 1'b1;
    load_pat   = 1'b0;
    pattern_in = '0;
    start      = 1'b0;
    repeat_cnt = '0;
    gap        = '0;
    pat_model  = 4'b1101;

    repeat (3) @(negedge clk);
    chk("rst.x_out", 32'(x_out), 32'd0);
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.frame_start", 32'(frame_start), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run("single", 1, 0, 1'b0, 4'h0, 1'b0);
    run("b2b3", 3, 0, 1'b0, 4'h0, 1'b0);
    run("gap2", 2, 2, 1'b0, 4'h0, 1'b0);
    run("load1011", 1, 0, 1'b1, 4'b1011, 1'b0);
    run("noise", 3, 1, 1'b0, 4'h0, 1'b1);
    run("rep0", 0, 3, 1'b0, 4'h0, 1'b0);
    run("ldstart", 2, 0, 1'b1, 4'b0110, 1'b0);
    run("maxgap", 2, 15, 1'b0, 4'h0, 1'b0);
    run("maxrep", 255, 0, 1'b1, 4'b1011, 1'b0);

    // Abort: reset during bit 2 of a rep=5 run
    @(negedge clk);
    start      = 1'b1;
    repeat_cnt = 8'd5;
    gap        = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("abort.pre_valid", 32'(valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort.x_out", 32'(x_out), 32'd0);
    chk("abort.valid", 32'(valid), 32'd0);
    chk("abort.frame_start", 32'(frame_start), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    pat_model = 4'b1101;
    repeat (2) begin
      @(negedge clk);
      chk("abort.no_done", 32'(done), 32'd0);
      chk("abort.idle", 32'(busy), 32'd0);
    end
    $display("run abort: reset mid-transmission, outputs cleared");
    run("post_abort", 2, 1, 1'b0, 4'h0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run($sformatf("rand%0d", k), $urandom_range(0, 6), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), PAT_W'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
